// File: rtl/rs_slot_allocator.sv
// Reservation-station slot allocator: registered free map, N-lane free-slot picker
// (lowest-first or rotating start), multi-lane release, flush and count tracking.
module rs_slot_allocator #(
   parameter int RS_SIZE        = 8,
   parameter int RS_INDEX_WIDTH = $clog2(RS_SIZE),
   parameter int ALLOC_WIDTH    = 2,
   parameter int FREE_WIDTH     = 2,
   parameter int ALLOC_POLICY   = 0
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   flush_i,
   input  logic [ALLOC_WIDTH-1:0]                 alloc_valid_i,
   output logic [ALLOC_WIDTH-1:0]                 alloc_ready_o,
   output logic [ALLOC_WIDTH*RS_INDEX_WIDTH-1:0]  alloc_index_o,
   input  logic [FREE_WIDTH-1:0]                  free_valid_i,
   input  logic [FREE_WIDTH*RS_INDEX_WIDTH-1:0]   free_index_i,
   output logic [RS_SIZE-1:0]                     rs_unused_o,
   output logic [$clog2(RS_SIZE+1)-1:0]           free_count_o
);
   localparam int IW = RS_INDEX_WIDTH;
   localparam int CW = $clog2(RS_SIZE+1);

   logic [RS_SIZE-1:0]            rs_unused_q, rs_unused_d;
   logic [CW-1:0]                 free_count_q, free_count_d;
   logic [IW-1:0]                 start_ptr_q, start_ptr_d;
   logic [ALLOC_WIDTH-1:0]        ready_s, fire_s;
   logic [ALLOC_WIDTH*IW-1:0]     index_s;
   logic [RS_SIZE-1:0]            free_mask_s, fire_mask_s;

   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int offs);
      logic [IW:0] sum;
      sum = {1'b0, base} + (IW+1)'(offs);
      if (sum >= (IW+1)'(RS_SIZE)) begin
         sum = sum - (IW+1)'(RS_SIZE);
      end else begin
         sum = sum;
      end
      return sum[IW-1:0];
   endfunction

   function automatic logic [CW-1:0] popcount(input logic [RS_SIZE-1:0] v);
      logic [CW-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         cnt = cnt + CW'(v[i]);
      end
      return cnt;
   endfunction

   // Lane k takes the (k+1)-th free slot met while scanning from the search origin.
   always_comb begin
      int            seen;
      logic [IW-1:0] pos;
      ready_s = '0;
      index_s = '0;
      seen    = 0;
      pos     = '0;
      for (int k = 0; k < ALLOC_WIDTH; k++) begin
         seen = 0;
         for (int i = 0; i < RS_SIZE; i++) begin
            pos = (ALLOC_POLICY == 1) ? wrap_add(start_ptr_q, i) : IW'(i);
            if (rs_unused_q[pos]) begin
               if (seen == k) begin
                  ready_s[k]            = 1'b1;
                  index_s[k*IW +: IW]   = pos;
               end else begin
                  ready_s[k] = ready_s[k];
               end
               seen = seen + 1;
            end else begin
               seen = seen;
            end
         end
      end
   end

   assign alloc_ready_o = rst_i ? '0 : ready_s;
   assign alloc_index_o = rst_i ? '0 : index_s;
   assign fire_s        = alloc_valid_i & alloc_ready_o;

   // Allocation clears after release sets, so an allocated slot always ends occupied.
   always_comb begin
      free_mask_s = '0;
      fire_mask_s = '0;
      start_ptr_d = start_ptr_q;
      for (int s = 0; s < RS_SIZE; s++) begin
         for (int j = 0; j < FREE_WIDTH; j++) begin
            free_mask_s[s] = free_mask_s[s] |
                             (free_valid_i[j] & (free_index_i[j*IW +: IW] == IW'(s)));
         end
         for (int k = 0; k < ALLOC_WIDTH; k++) begin
            fire_mask_s[s] = fire_mask_s[s] |
                             (fire_s[k] & (index_s[k*IW +: IW] == IW'(s)));
         end
      end
      for (int k = 0; k < ALLOC_WIDTH; k++) begin
         start_ptr_d = fire_s[k] ? wrap_add(index_s[k*IW +: IW], 1) : start_ptr_d;
      end
      if (flush_i || (ALLOC_POLICY != 1)) begin
         start_ptr_d = '0;
      end else begin
         start_ptr_d = start_ptr_d;
      end
      rs_unused_d  = flush_i ? '1 : ((rs_unused_q | free_mask_s) & ~fire_mask_s);
      free_count_d = popcount(rs_unused_d);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rs_unused_q  <= '1;
         free_count_q <= CW'(RS_SIZE);
         start_ptr_q  <= '0;
      end else begin
         rs_unused_q  <= rs_unused_d;
         free_count_q <= free_count_d;
         start_ptr_q  <= start_ptr_d;
      end
   end

   assign rs_unused_o  = rs_unused_q;
   assign free_count_o = free_count_q;

   rs_slot_allocator_chk #(
      .RS_SIZE     (RS_SIZE),
      .IW          (IW),
      .ALLOC_WIDTH (ALLOC_WIDTH),
      .FREE_WIDTH  (FREE_WIDTH),
      .CW          (CW)
   ) u_chk (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .flush_i       (flush_i),
      .alloc_valid_i (alloc_valid_i),
      .free_valid_i  (free_valid_i),
      .free_index_i  (free_index_i),
      .rs_unused_i   (rs_unused_q),
      .free_count_i  (free_count_q)
   );
endmodule

// Protocol and state-consistency checks for the slot allocator.
module rs_slot_allocator_chk #(
   parameter int RS_SIZE     = 8,
   parameter int IW          = 3,
   parameter int ALLOC_WIDTH = 2,
   parameter int FREE_WIDTH  = 2,
   parameter int CW          = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic [ALLOC_WIDTH-1:0]     alloc_valid_i,
   input  logic [FREE_WIDTH-1:0]      free_valid_i,
   input  logic [FREE_WIDTH*IW-1:0]   free_index_i,
   input  logic [RS_SIZE-1:0]         rs_unused_i,
   input  logic [CW-1:0]              free_count_i
);
   a_valid_contiguous: assert property (@(posedge clk_i) disable iff (rst_i)
      ((alloc_valid_i & (alloc_valid_i + ALLOC_WIDTH'(1))) == '0))
      else $error("alloc_valid_i has a gap: %b", alloc_valid_i);

   a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      (free_count_i <= CW'(RS_SIZE)))
      else $error("free_count out of range: %0d", free_count_i);

   for (genvar j = 0; j < FREE_WIDTH; j++) begin : g_free_chk
      a_free_occupied: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
         !(free_valid_i[j] && rs_unused_i[free_index_i[j*IW +: IW]]))
         else $warning("free lane %0d releases an already-free slot", j);
   end
endmodule

// File: tb/tb_rs_slot_allocator.sv
// Directed table-driven bench: policy 0 and policy 1 allocators checked against hand-computed rows.
module tb_rs_slot_allocator;
   logic       clk = 1'b0;
   logic       rst;
   logic       flush0, flush1;
   logic [1:0] av0, av1, ar0, ar1, fv0, fv1;
   logic [5:0] ai0, ai1, fi0, fi1;
   logic [7:0] un0, un1;
   logic [3:0] fc0, fc1;
   int         n_pass = 0;
   int         n_total = 0;

   always #5 clk = ~clk;

   rs_slot_allocator #(.ALLOC_POLICY(0)) u_p0 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush0), .alloc_valid_i(av0), .alloc_ready_o(ar0),
      .alloc_index_o(ai0), .free_valid_i(fv0), .free_index_i(fi0), .rs_unused_o(un0),
      .free_count_o(fc0));

   rs_slot_allocator #(.ALLOC_POLICY(1)) u_p1 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush1), .alloc_valid_i(av1), .alloc_ready_o(ar1),
      .alloc_index_o(ai1), .free_valid_i(fv1), .free_index_i(fi1), .rs_unused_o(un1),
      .free_count_o(fc1));

   typedef struct {
      logic       rst;
      logic       flush;
      logic [1:0] valid;
      logic [1:0] fvalid;
      logic [2:0] f0;
      logic [2:0] f1;
      logic [1:0] e_ready;
      logic [2:0] e_i0;
      logic [2:0] e_i1;
      logic [3:0] e_cnt;
      logic [7:0] e_unused;
   } vec_t;

   vec_t t0[17];
   vec_t t1[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // Drive one row onto the selected DUT (other DUT idle), then compare before the next edge.
   task automatic apply(input vec_t v, input bit sel, input string tag);
      @(negedge clk);
      rst = v.rst;
      flush0 = 1'b0; av0 = 2'b00; fv0 = 2'b00; fi0 = 6'd0;
      flush1 = 1'b0; av1 = 2'b00; fv1 = 2'b00; fi1 = 6'd0;
      if (sel == 1'b0) begin
         flush0 = v.flush; av0 = v.valid; fv0 = v.fvalid; fi0 = {v.f1, v.f0};
      end else begin
         flush1 = v.flush; av1 = v.valid; fv1 = v.fvalid; fi1 = {v.f1, v.f0};
      end
      #1;
      if (sel == 1'b0) begin
         chk({tag, " ready"},  32'(ar0),      32'(v.e_ready));
         chk({tag, " idx0"},   32'(ai0[2:0]), 32'(v.e_i0));
         chk({tag, " idx1"},   32'(ai0[5:3]), 32'(v.e_i1));
         chk({tag, " count"},  32'(fc0),      32'(v.e_cnt));
         chk({tag, " unused"}, 32'(un0),      32'(v.e_unused));
      end else begin
         chk({tag, " ready"},  32'(ar1),      32'(v.e_ready));
         chk({tag, " idx0"},   32'(ai1[2:0]), 32'(v.e_i0));
         chk({tag, " idx1"},   32'(ai1[5:3]), 32'(v.e_i1));
         chk({tag, " count"},  32'(fc1),      32'(v.e_cnt));
         chk({tag, " unused"}, 32'(un1),      32'(v.e_unused));
      end
   endtask

   initial begin
      // rst flush valid fvalid f0 f1 | ready i0 i1 count unused   (policy 0)
      t0[0]  = '{1'b1, 1'b0, 2'b11, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 3'd0, 4'd8, 8'hFF};
      t0[1]  = '{1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 3'd0, 2'b11, 3'd0, 3'd1, 4'd8, 8'hFF};
      t0[2]  = '{1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 3'd0, 2'b11, 3'd2, 3'd3, 4'd6, 8'hFC};
      t0[3]  = '{1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 3'd0, 2'b11, 3'd4, 3'd5, 4'd4, 8'hF0};
      t0[4]  = '{1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 3'd0, 2'b11, 3'd6, 3'd7, 4'd2, 8'hC0};
      t0[5]  = '{1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 3'd0, 4'd0, 8'h00};
      t0[6]  = '{1'b0, 1'b0, 2'b00, 2'b11, 3'd3, 3'd6, 2'b00, 3'd0, 3'd0, 4'd0, 8'h00};
      t0[7]  = '{1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 3'd0, 2'b11, 3'd3, 3'd6, 4'd2, 8'h48};
      t0[8]  = '{1'b0, 1'b0, 2'b00, 2'b01, 3'd5, 3'd0, 2'b00, 3'd0, 3'd0, 4'd0, 8'h00};
      t0[9]  = '{1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 3'd0, 2'b01, 3'd5, 3'd0, 4'd1, 8'h20};
      t0[10] = '{1'b0, 1'b0, 2'b00, 2'b11, 3'd2, 3'd2, 2'b00, 3'd0, 3'd0, 4'd0, 8'h00};
      t0[11] = '{1'b0, 1'b0, 2'b01, 2'b00, 3'd0, 3'd0, 2'b01, 3'd2, 3'd0, 4'd1, 8'h04};
      t0[12] = '{1'b0, 1'b0, 2'b00, 2'b11, 3'd0, 3'd7, 2'b00, 3'd0, 3'd0, 4'd0, 8'h00};
      t0[13] = '{1'b0, 1'b1, 2'b11, 2'b01, 3'd4, 3'd0, 2'b11, 3'd0, 3'd7, 4'd2, 8'h81};
      t0[14] = '{1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 3'd0, 2'b11, 3'd0, 3'd1, 4'd8, 8'hFF};
      t0[15] = '{1'b1, 1'b0, 2'b11, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 3'd0, 4'd6, 8'hFC};
      t0[16] = '{1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 2'b11, 3'd0, 3'd1, 4'd8, 8'hFF};

      // policy 1: rotating start pointer
      t1[0]  = '{1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 3'd0, 2'b11, 3'd0, 3'd1, 4'd8, 8'hFF};
      t1[1]  = '{1'b0, 1'b0, 2'b00, 2'b11, 3'd0, 3'd1, 2'b11, 3'd2, 3'd3, 4'd6, 8'hFC};
      t1[2]  = '{1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 2'b11, 3'd2, 3'd3, 4'd8, 8'hFF};
      t1[3]  = '{1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 3'd0, 2'b11, 3'd2, 3'd3, 4'd8, 8'hFF};
      t1[4]  = '{1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 3'd0, 2'b11, 3'd4, 3'd5, 4'd6, 8'hF3};
      t1[5]  = '{1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 3'd0, 2'b11, 3'd6, 3'd7, 4'd4, 8'hC3};
      t1[6]  = '{1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 3'd0, 2'b11, 3'd0, 3'd1, 4'd2, 8'h03};
      t1[7]  = '{1'b0, 1'b0, 2'b00, 2'b11, 3'd7, 3'd1, 2'b00, 3'd0, 3'd0, 4'd0, 8'h00};
      t1[8]  = '{1'b0, 1'b0, 2'b01, 2'b00, 3'd0, 3'd0, 2'b11, 3'd7, 3'd1, 4'd2, 8'h82};
      t1[9]  = '{1'b0, 1'b1, 2'b01, 2'b00, 3'd0, 3'd0, 2'b01, 3'd1, 3'd0, 4'd1, 8'h02};
      t1[10] = '{1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 3'd0, 2'b11, 3'd0, 3'd1, 4'd8, 8'hFF};
      t1[11] = '{1'b1, 1'b0, 2'b11, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 3'd0, 4'd6, 8'hFC};
      t1[12] = '{1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 2'b11, 3'd0, 3'd1, 4'd8, 8'hFF};

      rst = 1'b1;
      flush0 = 1'b0; av0 = 2'b00; fv0 = 2'b00; fi0 = 6'd0;
      flush1 = 1'b0; av1 = 2'b00; fv1 = 2'b00; fi1 = 6'd0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 17; i++) apply(t0[i], 1'b0, $sformatf("p0[%0d]", i));
      for (int i = 0; i < 13; i++) apply(t1[i], 1'b1, $sformatf("p1[%0d]", i));

      // Policy 1: after the reset the pointer must be back at 0, then allocating 0,1 moves it to 2.
      @(negedge clk);
      av1 = 2'b11;
      #1;
      chk("p1 post-reset idx0", 32'(ai1[2:0]), 32'd0);
      @(negedge clk);
      av1 = 2'b00;
      #1;
      chk("p1 ptr after alloc idx0", 32'(ai1[2:0]), 32'd2);
      chk("p1 ptr after alloc idx1", 32'(ai1[5:3]), 32'd3);
      chk("p1 ptr after alloc count", 32'(fc1), 32'd6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
